// File: rtl/id_ex_pipe_stage.sv
// -----------------------------------------------------------------------------
// id_ex_pipe_stage
//
// Flow-controlled ID->EX pipeline register with a two-entry skid buffer,
// synchronous flush (bubble insertion) and configurable immediate extension.
// The main entry drives the outputs; the skid entry absorbs the single
// in-flight transfer that arrives while the execute stage back-pressures.
//
// Ports:
//   clk, rst          clock (rising edge) and asynchronous active-high reset
//   flush             synchronous squash of every held entry
//   in_valid/in_ready upstream handshake (in_ready is registered)
//   in_ctrl/in_data   control and data bundles from decode
//   in_imm            raw immediate, extended at capture time
//   out_valid/out_ready downstream handshake
//   out_ctrl          control of the main entry, CTRL_BUBBLE when invalid
//   out_data/out_imm  data bundle and extended immediate of the main entry
//   occupancy         number of held entries (0..2)
//   stall_cnt         saturating count of back-pressured output cycles
// -----------------------------------------------------------------------------
module id_ex_pipe_stage #(
    parameter int                CTRL_W      = 10,
    parameter int                DATA_W      = 79,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = {CTRL_W{1'b0}},
    parameter int                IMM_IN_W    = 16,
    parameter int                IMM_OUT_W   = 32,
    parameter int                IMM_SIGNED  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CTRL_W-1:0]    in_ctrl,
    input  logic [DATA_W-1:0]    in_data,
    input  logic [IMM_IN_W-1:0]  in_imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CTRL_W-1:0]    out_ctrl,
    output logic [DATA_W-1:0]    out_data,
    output logic [IMM_OUT_W-1:0] out_imm,
    output logic [1:0]           occupancy,
    output logic [15:0]          stall_cnt
);

    // Extend the raw immediate to the output width (sign or zero).
    function automatic logic [IMM_OUT_W-1:0] extend_imm(input logic [IMM_IN_W-1:0] imm);
        if (IMM_SIGNED != 0) begin
            return IMM_OUT_W'($signed(imm));
        end else begin
            return IMM_OUT_W'(imm);
        end
    endfunction

    logic                 main_valid_r, main_valid_s;
    logic [CTRL_W-1:0]    main_ctrl_r,  main_ctrl_s;
    logic [DATA_W-1:0]    main_data_r,  main_data_s;
    logic [IMM_OUT_W-1:0] main_imm_r,   main_imm_s;
    logic                 skid_valid_r, skid_valid_s;
    logic [CTRL_W-1:0]    skid_ctrl_r,  skid_ctrl_s;
    logic [DATA_W-1:0]    skid_data_r,  skid_data_s;
    logic [IMM_OUT_W-1:0] skid_imm_r,   skid_imm_s;
    logic                 in_ready_r;
    logic [1:0]           occ_r,        occ_s;
    logic [15:0]          stall_cnt_r,  stall_cnt_s;
    logic [IMM_OUT_W-1:0] in_imm_ext_s;
    logic                 in_fire_s;

    // Next-state computation for both entries, occupancy and stall counter.
    always_comb begin
        main_valid_s = main_valid_r;
        main_ctrl_s  = main_ctrl_r;
        main_data_s  = main_data_r;
        main_imm_s   = main_imm_r;
        skid_valid_s = skid_valid_r;
        skid_ctrl_s  = skid_ctrl_r;
        skid_data_s  = skid_data_r;
        skid_imm_s   = skid_imm_r;
        in_imm_ext_s = extend_imm(in_imm);
        in_fire_s    = in_valid & in_ready_r;

        if (flush) begin
            // Data and imm are left alone; only control is scrubbed.
            main_valid_s = 1'b0;
            skid_valid_s = 1'b0;
            main_ctrl_s  = CTRL_BUBBLE;
        end else begin
            case ({main_valid_r, skid_valid_r})
                2'b00: begin
                    if (in_fire_s) begin
                        main_valid_s = 1'b1;
                        main_ctrl_s  = in_ctrl;
                        main_data_s  = in_data;
                        main_imm_s   = in_imm_ext_s;
                    end else begin
                        main_valid_s = 1'b0;
                    end
                end
                2'b10: begin
                    if (in_fire_s && out_ready) begin
                        main_ctrl_s  = in_ctrl;
                        main_data_s  = in_data;
                        main_imm_s   = in_imm_ext_s;
                    end else if (in_fire_s) begin
                        skid_valid_s = 1'b1;
                        skid_ctrl_s  = in_ctrl;
                        skid_data_s  = in_data;
                        skid_imm_s   = in_imm_ext_s;
                    end else if (out_ready) begin
                        // Keeping ctrl at the bubble value lets out_ctrl stay a plain flop.
                        main_valid_s = 1'b0;
                        main_ctrl_s  = CTRL_BUBBLE;
                    end else begin
                        main_valid_s = 1'b1;
                    end
                end
                2'b11: begin
                    if (out_ready) begin
                        main_ctrl_s  = skid_ctrl_r;
                        main_data_s  = skid_data_r;
                        main_imm_s   = skid_imm_r;
                        skid_valid_s = 1'b0;
                    end else begin
                        skid_valid_s = 1'b1;
                    end
                end
                default: begin
                    // Skid-only is unreachable; collapse to a clean empty stage.
                    main_valid_s = 1'b0;
                    skid_valid_s = 1'b0;
                    main_ctrl_s  = CTRL_BUBBLE;
                end
            endcase
        end

        occ_s = {1'b0, main_valid_s} + {1'b0, skid_valid_s};

        if (main_valid_r && !out_ready && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_s = stall_cnt_r + 16'd1;
        end else begin
            stall_cnt_s = stall_cnt_r;
        end
    end

    // State registers; in_ready is precomputed from the next skid valid bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_r <= 1'b0;
            main_ctrl_r  <= CTRL_BUBBLE;
            main_data_r  <= {DATA_W{1'b0}};
            main_imm_r   <= {IMM_OUT_W{1'b0}};
            skid_valid_r <= 1'b0;
            skid_ctrl_r  <= {CTRL_W{1'b0}};
            skid_data_r  <= {DATA_W{1'b0}};
            skid_imm_r   <= {IMM_OUT_W{1'b0}};
            in_ready_r   <= 1'b1;
            occ_r        <= 2'd0;
            stall_cnt_r  <= 16'd0;
        end else begin
            main_valid_r <= main_valid_s;
            main_ctrl_r  <= main_ctrl_s;
            main_data_r  <= main_data_s;
            main_imm_r   <= main_imm_s;
            skid_valid_r <= skid_valid_s;
            skid_ctrl_r  <= skid_ctrl_s;
            skid_data_r  <= skid_data_s;
            skid_imm_r   <= skid_imm_s;
            in_ready_r   <= !skid_valid_s;
            occ_r        <= occ_s;
            stall_cnt_r  <= stall_cnt_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = main_valid_r;
    assign out_ctrl  = main_ctrl_r;
    assign out_data  = main_data_r;
    assign out_imm   = main_imm_r;
    assign occupancy = occ_r;
    assign stall_cnt = stall_cnt_r;

endmodule
